// File: rtl/ucsbece154b_icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package ucsbece154b_icache_pkg;

  typedef enum logic [1:0] {
    ic_IDLE = 2'd0,
    ic_REQ  = 2'd1,
    ic_FILL = 2'd2
  } ic_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ucsbece154b_icache_ctrl.sv
// Miss/fill sequencer: latches the missing line address, pulses one memory
// request, then counts the burst words back in ascending order.
module ucsbece154b_icache_ctrl
  import ucsbece154b_icache_pkg::*;
#(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           miss,
  input  logic [ADDR_W-1:0]              miss_line,
  input  logic                           mem_ready,
  output logic                           idle,
  output logic                           mem_req,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           fill_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_cnt,
  output logic                           fill_done
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);

  ic_state_e state, state_next;

  assign idle      = (state == ic_IDLE);
  assign mem_req   = (state == ic_REQ);
  assign fill_we   = (state == ic_FILL) && mem_ready;
  assign fill_done = fill_we && (fill_cnt == OFF_W'(BLOCK_WORDS - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ic_IDLE;
      fill_cnt <= '0;
      mem_addr <= '0;
    end else begin
      state <= state_next;
      if (state == ic_IDLE && miss) mem_addr <= miss_line;
      if (state == ic_REQ)          fill_cnt <= '0;
      else if (fill_we)             fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ic_IDLE: if (miss) state_next = ic_REQ;
      ic_REQ:  state_next = ic_FILL;
      ic_FILL: if (fill_done) state_next = ic_IDLE;
      default: state_next = ic_IDLE;
    endcase
  end

endmodule

// File: rtl/ucsbece154b_icache.sv
// Direct-mapped read-only instruction cache: combinational lookup of PCF,
// stall and burst line fill on a miss.
module ucsbece154b_icache
  import ucsbece154b_icache_pkg::*;
#(
  parameter int NUM_SETS    = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PCF_i,
  input  logic              ReadEnable_i,
  output logic [31:0]       InstrF_o,
  output logic              Hit_o,
  output logic              Busy_o,
  output logic [ADDR_W-1:0] MemReadAddress_o,
  output logic              MemReadRequest_o,
  input  logic [31:0]       MemDataIn_i,
  input  logic              MemDataReady_i
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

  logic [OFF_W-1:0] pc_off, fill_cnt;
  logic [IDX_W-1:0] pc_idx, miss_idx;
  logic [TAG_W-1:0] pc_tag, miss_tag;

  logic             idle, miss, lookup_hit, fill_we, fill_done;
  logic [ADDR_W-1:0] miss_line;

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tags [NUM_SETS];
  logic [31:0]         data [NUM_SETS][BLOCK_WORDS];

  logic unused_pc_bits;
  assign unused_pc_bits = ^PCF_i[1:0];

  assign pc_off   = PCF_i[2 +: OFF_W];
  assign pc_idx   = PCF_i[OFF_W+2 +: IDX_W];
  assign pc_tag   = PCF_i[ADDR_W-1 -: TAG_W];
  assign miss_idx = MemReadAddress_o[OFF_W+2 +: IDX_W];
  assign miss_tag = MemReadAddress_o[ADDR_W-1 -: TAG_W];

  assign miss_line  = {pc_tag, pc_idx, {(OFF_W + 2){1'b0}}};
  assign lookup_hit = valid[pc_idx] && (tags[pc_idx] == pc_tag);
  assign miss       = ReadEnable_i && !lookup_hit;

  assign Hit_o    = ReadEnable_i && lookup_hit && idle;
  assign InstrF_o = Hit_o ? data[pc_idx][pc_off] : NOP_INSTR;
  assign Busy_o   = (ReadEnable_i && !Hit_o) || !idle;

  ucsbece154b_icache_ctrl #(
    .BLOCK_WORDS(BLOCK_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .miss     (miss),
    .miss_line(miss_line),
    .mem_ready(MemDataReady_i),
    .idle     (idle),
    .mem_req  (MemReadRequest_o),
    .mem_addr (MemReadAddress_o),
    .fill_we  (fill_we),
    .fill_cnt (fill_cnt),
    .fill_done(fill_done)
  );

  // The victim set is invalidated at request time so a fill cut short by
  // reset or still in flight can never be looked up as a stale line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (MemReadRequest_o) begin
      valid[miss_idx] <= 1'b0;
    end else if (fill_done) begin
      valid[miss_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone
  // decide whether their contents are meaningful, so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fill_we)   data[miss_idx][fill_cnt] <= MemDataIn_i;
    if (fill_done) tags[miss_idx]           <= miss_tag;
  end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Self-checking bench: directed scenarios plus randomized accesses compared
// against a line-residency model of a direct-mapped cache over a fixed memory.
module tb_ucsbece154b_icache;

  localparam int NUM_SETS   = 32;
  localparam int BW         = 4;
  localparam int LINE_BYTES = BW * 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcf;
  logic        re;
  logic [31:0] instr;
  logic        hit, busy;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_data;
  logic        mem_ready;

  int vectors    = 0;
  int miscompares = 0;

  // Model: which line address each set currently holds.
  logic [31:0] resident [NUM_SETS];
  bit          res_valid [NUM_SETS];
  bit          ready_pat [$];

  ucsbece154b_icache #(.NUM_SETS(NUM_SETS), .BLOCK_WORDS(BW), .ADDR_W(32)) dut (
    .clk             (clk),
    .reset           (rst_n),
    .PCF_i           (pcf),
    .ReadEnable_i    (re),
    .InstrF_o        (instr),
    .Hit_o           (hit),
    .Busy_o          (busy),
    .MemReadAddress_o(mem_addr),
    .MemReadRequest_o(mem_req),
    .MemDataIn_i     (mem_data),
    .MemDataReady_i  (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h0001_0000 && a < 32'h0001_0010) return 32'hA0 + (a - 32'h0001_0000) / 4;
    return (a * 32'h9E37_79B1) ^ 32'h5555_0000;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a - (a % LINE_BYTES);
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % NUM_SETS);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return res_valid[set_of(a)] && resident[set_of(a)] == line_of(a);
  endfunction

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
    end
  endtask

  // Called at the negedge of the REQ cycle; returns at the negedge after the
  // last word (or early, before the word numbered abort_after).
  task automatic serve_miss(input logic [31:0] line, input int lat, input bit bubbles,
                            input bit redir, input logic [31:0] redir_pc,
                            input bit drop_re, input int abort_after, output bit aborted);
    int k;
    int cyc;
    bit rdy;
    aborted = 1'b0;
    #1;
    chk("req_pulse", mem_req, 1'b1);
    chk("req_addr", mem_addr, line);
    chk("req_busy", busy, 1'b1);
    chk("req_hit", hit, 1'b0);
    @(negedge clk);
    k = 0;
    cyc = 0;
    while (k < BW) begin
      if (k == abort_after) begin
        aborted = 1'b1;
        return;
      end
      if (redir && k == 1) pcf = redir_pc;
      if (drop_re && k == 2) re = 1'b0;
      if (cyc < lat)                 rdy = 1'b0;
      else if (ready_pat.size() > 0) rdy = ready_pat.pop_front();
      else if (bubbles && cyc < 30)  rdy = 1'($urandom_range(0, 1));
      else                           rdy = 1'b1;
      mem_ready = rdy;
      mem_data  = rdy ? mem_word(line + 32'(4 * k)) : 32'hDEAD_BEEF;
      #1;
      chk("fill_req", mem_req, 1'b0);
      chk("fill_busy", busy, 1'b1);
      chk("fill_hit", hit, 1'b0);
      chk("fill_addr", mem_addr, line);
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_data  = 32'h0;
    re        = 1'b1;
    resident[set_of(line)]  = line;
    res_valid[set_of(line)] = 1'b1;
  endtask

  // Drives pc from a negedge, handles any misses, returns at a negedge after the hit.
  task automatic access(input logic [31:0] pc, input int lat, input bit bubbles,
                        input bit redir, input logic [31:0] redir_pc, input bit drop_re);
    bit ab;
    logic [31:0] line;
    bit rd, dr;
    rd = redir;
    dr = drop_re;
    pcf = pc;
    re  = 1'b1;
    for (int it = 0; it < 4; it++) begin
      // Stray ready in IDLE/REQ must be ignored.
      mem_ready = 1'b1;
      mem_data  = 32'hBAD0_0000;
      #1;
      if (model_hit(pcf)) begin
        chk("hit", hit, 1'b1);
        chk("hit_instr", instr, mem_word(pcf & ~32'h3));
        chk("hit_busy", busy, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        return;
      end
      chk("miss_hit", hit, 1'b0);
      chk("miss_busy", busy, 1'b1);
      chk("miss_instr", instr, NOP);
      chk("miss_noreq", mem_req, 1'b0);
      line = line_of(pcf);
      @(negedge clk);
      serve_miss(line, lat, bubbles, rd, redir_pc, dr, -1, ab);
      rd = 1'b0;
      dr = 1'b0;
    end
    vectors++;
    miscompares++;
    $error("FAIL access_loop pc=%h never hit after 4 fills", pc);
  endtask

  initial begin
    bit ab;
    logic [31:0] pool [6];
    logic [31:0] pc;
    pool = '{32'h0001_0000, 32'h0001_0200, 32'h0000_3000, 32'h0000_3010,
             32'h0000_07F0, 32'hFFFF_FFF0};
    for (int s = 0; s < NUM_SETS; s++) res_valid[s] = 1'b0;

    rst_n = 1'b0; re = 1'b0; pcf = 32'h0001_0000; mem_ready = 1'b0; mem_data = 32'h0;
    #1;
    chk("rst_hit", hit, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_instr", instr, NOP);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss, latency 3, then a same-line hit at offset 2.
    access(32'h0001_0000, 3, 1'b0, 1'b0, 32'h0, 1'b0);
    pcf = 32'h0001_0008;
    #1;
    chk("cold_hit2", hit, 1'b1);
    chk("cold_a2", instr, 32'h0000_00A2);
    chk("cold_busy2", busy, 1'b0);
    @(negedge clk);

    // Conflict eviction: same index, different tag, then back again.
    access(32'h0001_0200, 1, 1'b0, 1'b0, 32'h0, 1'b0);
    access(32'h0001_0004, 0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect mid-fill: 0x100 completes, then 0x400 is fetched, then 0x104 hits.
    access(32'h0000_0100, 2, 1'b0, 1'b1, 32'h0000_0400, 1'b0);
    access(32'h0000_0104, 0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Bubbly memory ready pattern.
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    access(32'h0000_5000, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    access(32'h0000_500C, 0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Fetch disabled on a missing address: nothing happens.
    pcf = 32'h0002_0000; re = 1'b0; mem_ready = 1'b0;
    #1;
    chk("re0_hit", hit, 1'b0);
    chk("re0_busy", busy, 1'b0);
    chk("re0_instr", instr, NOP);
    @(negedge clk);
    #1;
    chk("re0_noreq", mem_req, 1'b0);
    chk("re0_busy2", busy, 1'b0);
    @(negedge clk);

    // Reset after two fill words; line stays invalid and is refetched.
    pcf = 32'h0000_2040; re = 1'b1;
    #1;
    chk("rmf_miss", hit, 1'b0);
    @(negedge clk);
    serve_miss(32'h0000_2040, 1, 1'b0, 1'b0, 32'h0, 1'b0, 2, ab);
    rst_n = 1'b0; re = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rmf_hit", hit, 1'b0);
    chk("rmf_busy", busy, 1'b0);
    chk("rmf_req", mem_req, 1'b0);
    chk("rmf_addr", mem_addr, 32'h0);
    chk("rmf_instr", instr, NOP);
    for (int s = 0; s < NUM_SETS; s++) res_valid[s] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(32'h0000_2040, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    access(32'h0001_0200, 0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized accesses over a small conflicting pool.
    for (int n = 0; n < 60; n++) begin
      pc = pool[$urandom_range(0, 5)] + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      access(pc, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 4) == 0), pool[$urandom_range(0, 5)],
             ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
